// File: rtl/req_gnt_pkg.sv
// Shared parameters and helpers for the req/en/gnt requester-side client.
// Helpers work on a fixed-width vector so any line count up to MAX_N can share them.
package req_gnt_pkg;

    localparam int unsigned N_DEF            = 4;
    localparam int unsigned CNT_W_DEF        = 2;
    localparam int unsigned STARVE_LIMIT_DEF = 8;
    localparam int unsigned MAX_N            = 32;
    localparam int unsigned MAX_IDX_W        = $clog2(MAX_N);

    typedef enum logic {
        ERR_OK  = 1'b0,
        ERR_SET = 1'b1
    } err_state_e;

    // True when exactly one bit of v is set.
    function automatic logic onehot_chk(input logic [MAX_N-1:0] v);
        return (v != '0) && ((v & (v - MAX_N'(1))) == '0);
    endfunction

    // OR-of-indices encoder: exact for one-hot input, no priority chain.
    function automatic logic [MAX_IDX_W-1:0] onehot_idx(input logic [MAX_N-1:0] v);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (v[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/req_gnt_line.sv
// One request line: saturating pending counter, starvation wait counter and drop pulse.
module req_gnt_line
    import req_gnt_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             new_req,
    input  logic             acc,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             req,
    output logic             drop,
    output logic             starve
);

    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic [CNT_W-1:0]  pend_next;
    logic              drop_next;
    logic              full;

    assign req    = (pend_cnt != '0);
    assign full   = (pend_cnt == {CNT_W{1'b1}});
    assign starve = (wait_cnt == WAIT_W'(STARVE_LIMIT));

    // Next-state for pending count, drop pulse and wait counter.
    always_comb begin
        pend_next = pend_cnt;
        drop_next = 1'b0;
        wait_next = wait_cnt;

        case ({new_req, acc})
            2'b10: begin
                if (full) begin
                    drop_next = 1'b1;
                end else begin
                    pend_next = pend_cnt + CNT_W'(1);
                end
            end
            2'b01: begin
                if (req) begin
                    pend_next = pend_cnt - CNT_W'(1);
                end
            end
            default: begin
                pend_next = pend_cnt;
            end
        endcase

        if (!req || acc) begin
            wait_next = '0;
        end else if (wait_cnt != WAIT_W'(STARVE_LIMIT)) begin
            wait_next = wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_cnt <= '0;
            wait_cnt <= '0;
            drop     <= 1'b0;
        end else begin
            pend_cnt <= pend_next;
            wait_cnt <= wait_next;
            drop     <= drop_next;
        end
    end

endmodule

// File: rtl/req_gnt_client.sv
// Requester-side end of the req/en/gnt handshake: per-line queues, grant legality
// checking, served-index reporting and a sticky protocol-error flag.
module req_gnt_client
    import req_gnt_pkg::*;
#(
    parameter int unsigned N            = N_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N-1:0]             new_req,
    input  logic [N-1:0]             gnt,
    output logic [N-1:0]             req,
    output logic                     en,
    output logic [N-1:0][CNT_W-1:0]  pend_cnt,
    output logic                     served_valid,
    output logic [$clog2(N)-1:0]     served_idx,
    output logic [N-1:0]             drop,
    output logic [N-1:0]             starve,
    output logic                     proto_err
);

    localparam int unsigned IDX_W = $clog2(N);

    logic       gnt_legal;
    logic [N-1:0] acc;
    err_state_e err_state;
    err_state_e err_next;

    assign en = |req;

    // A grant is legal only if idle, or one-hot onto a currently requesting line.
    always_comb begin
        gnt_legal = (gnt == '0)
                 || (onehot_chk(MAX_N'(gnt)) && ((gnt & req) == gnt) && en);
        acc       = gnt_legal ? gnt : '0;
    end

    for (genvar i = 0; i < int'(N); i++) begin : g_line
        req_gnt_line #(
            .CNT_W        (CNT_W),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_line (
            .clock    (clock),
            .reset    (reset),
            .new_req  (new_req[i]),
            .acc      (acc[i]),
            .pend_cnt (pend_cnt[i]),
            .req      (req[i]),
            .drop     (drop[i]),
            .starve   (starve[i])
        );
    end

    // Sticky error: any illegal grant latches ERR_SET until reset.
    always_comb begin
        err_next = err_state;
        if (!gnt_legal) begin
            err_next = ERR_SET;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_state <= ERR_OK;
        end else begin
            err_state <= err_next;
        end
    end

    assign proto_err = (err_state == ERR_SET);

    always_ff @(posedge clock) begin
        if (reset) begin
            served_valid <= 1'b0;
            served_idx   <= '0;
        end else begin
            served_valid <= |acc;
            served_idx   <= (|acc) ? IDX_W'(onehot_idx(MAX_N'(acc))) : '0;
        end
    end

endmodule
